// File: rtl/core_mem_pkg.sv
// Shared definitions for the core's req/gnt memory bus and its responders.
package core_mem_pkg;

  localparam int unsigned DEF_MEM_ADDR_W = 64;
  localparam int unsigned DEF_MEM_DATA_W = 64;
  localparam int unsigned DEF_MEM_STRB_W = DEF_MEM_DATA_W / 8;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_fsm_t;

endpackage

// File: rtl/mem_stall_lfsr.sv
// 16-bit Fibonacci LFSR that supplies pseudo-random grant stall lengths.
module mem_stall_lfsr
  import core_mem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        step,
  output logic [15:0] lfsr
);

  // Shift right once per step, feeding the XOR of the tap bits into bit 15
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Environment-side memory model for the core's req/gnt bus: byte-strobed RAM,
// bounded pseudo-random grant stalls, and bus errors outside the RAM window.
module mem_bus_responder
  import core_mem_pkg::*;
#(
  parameter int unsigned           MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int unsigned           MEM_DATA_W = DEF_MEM_DATA_W,
  parameter int unsigned           MEM_STRB_W = MEM_DATA_W / 8,
  parameter logic [MEM_ADDR_W-1:0] MEM_BASE   = '0,
  parameter int unsigned           MEM_DEPTH  = 1024,
  parameter int unsigned           MAX_STALL  = 4,
  parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  stall_en,
  input  logic                  mem_req,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_wen,
  input  logic [MEM_STRB_W-1:0] mem_strb,
  input  logic [MEM_DATA_W-1:0] mem_wdata,
  output logic                  mem_gnt,
  output logic                  mem_err,
  output logic [MEM_DATA_W-1:0] mem_rdata
);

  localparam int unsigned OFF_W = $clog2(MEM_STRB_W);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  // One extra bit so the window size never wraps, whatever the base
  localparam logic [MEM_ADDR_W:0] MEM_BYTES = (MEM_ADDR_W + 1)'(MEM_DEPTH * MEM_STRB_W);

  mem_fsm_t              state;
  logic [3:0]            stall_ctr;
  logic [3:0]            stall_pick;
  logic [15:0]           lfsr;
  logic                  lfsr_step;
  logic [MEM_ADDR_W-1:0] addr_off;
  logic                  addr_hit;
  logic [IDX_W-1:0]      word_idx;
  logic                  unused_addr_off;
  logic [MEM_DATA_W-1:0] ram [MEM_DEPTH];

  // The LFSR advances only when a request is evaluated in IDLE, so the stall
  // sequence depends on request count alone
  assign lfsr_step = (state == IDLE) && mem_req;

  mem_stall_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .step    (lfsr_step),
    .lfsr    (lfsr)
  );

  assign stall_pick = stall_en ? 4'(32'(lfsr[3:0]) % (MAX_STALL + 1)) : 4'd0;

  // Grant depends only on req, reset and registered state, never on addr/data
  always_comb begin
    mem_gnt = 1'b0;
    if (g_resetn && mem_req) begin
      case (state)
        IDLE:    mem_gnt = (stall_pick == 4'd0);
        WAIT:    mem_gnt = (stall_ctr == 4'd0);
        default: mem_gnt = 1'b0;
      endcase
    end
  end

  // Window decode: offset from base, range-checked without wraparound
  always_comb begin
    addr_off        = mem_addr - MEM_BASE;
    addr_hit        = (mem_addr >= MEM_BASE) && ({1'b0, addr_off} < MEM_BYTES);
    word_idx        = addr_off[OFF_W +: IDX_W];
    unused_addr_off = ^addr_off;
  end

  // Stall FSM: IDLE picks a stall length, WAIT counts it down or abandons on req drop
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state     <= IDLE;
      stall_ctr <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req && (stall_pick != 4'd0)) begin
            stall_ctr <= stall_pick - 4'd1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (!mem_req || (stall_ctr == 4'd0)) begin
            state <= IDLE;
          end else begin
            stall_ctr <= stall_ctr - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM write port: byte lanes updated on a granted write that hits the window
  always_ff @(posedge g_clk) begin
    if (mem_gnt && mem_wen && addr_hit) begin
      for (int i = 0; i < int'(MEM_STRB_W); i++) begin
        if (mem_strb[i]) begin
          ram[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered response one cycle after grant; rdata holds when nothing was granted
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else if (mem_gnt) begin
      if (!addr_hit) begin
        mem_err   <= 1'b1;
        mem_rdata <= '0;
      end else if (mem_wen) begin
        mem_err   <= 1'b0;
        mem_rdata <= '0;
      end else begin
        mem_err   <= 1'b0;
        mem_rdata <= ram[word_idx];
      end
    end else begin
      mem_err <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  logic                  hold_pending;
  logic [MEM_ADDR_W-1:0] hold_addr;
  logic                  hold_wen;
  logic [MEM_STRB_W-1:0] hold_strb;
  logic [MEM_DATA_W-1:0] hold_wdata;

  // Flag an initiator that changes the request payload while waiting for grant
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      hold_pending <= 1'b0;
      hold_addr    <= '0;
      hold_wen     <= 1'b0;
      hold_strb    <= '0;
      hold_wdata   <= '0;
    end else begin
      if (hold_pending && mem_req &&
          ((mem_addr != hold_addr) || (mem_wen != hold_wen) ||
           (mem_strb != hold_strb) || (mem_wdata != hold_wdata))) begin
        $error("mem_bus_responder: request payload changed while req=1 and gnt=0");
      end
      hold_pending <= mem_req && !mem_gnt;
      hold_addr    <= mem_addr;
      hold_wen     <= mem_wen;
      hold_strb    <= mem_strb;
      hold_wdata   <= mem_wdata;
    end
  end
`endif

endmodule
